// File: rtl/osd_pkg.sv
// Shared definitions for the OSD character-RAM writer.
//   osd_wr_state_t : writer FSM states
//   CC_*           : control codes recognised in the byte stream
//   hex_ascii()    : nibble -> uppercase ASCII hex digit
package osd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ESC_COL = 3'd1,
    ST_ESC_ROW = 3'd2,
    ST_HEX_LO  = 3'd3,
    ST_CLEAR   = 3'd4
  } osd_wr_state_t;

  localparam logic [7:0] CC_CR  = 8'h0D;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_ESC = 8'h1B;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return 8'h30 + {4'h0, nibble};
    else                return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/osd_console_writer.sv
// Byte-stream front end for the OSD character RAM.
// Accepts text, control codes, ESC cursor positioning and hex-dump bytes over
// a valid/ready handshake, tracks a text cursor and drives single-cycle writes
// into the 40x30 character RAM.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   in_valid/in_ready     byte handshake; in_data byte, in_hex = print as hex
//   clear_req             one-cycle request to blank the screen and home
//   wr_addr/wr_data/wr_en registered char RAM write port
//   busy                  high while clearing or emitting the low hex digit
//   cursor_col/cursor_row current cursor position
module osd_console_writer
  import osd_pkg::*;
#(
  parameter int         COLS       = 40,
  parameter int         ROWS       = 30,
  parameter int         ADDR_WIDTH = 11,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_hex,
  input  logic                  clear_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  wr_en,
  output logic                  busy,
  output logic [5:0]            cursor_col,
  output logic [4:0]            cursor_row
);

  localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(COLS*ROWS-1);
  localparam logic [5:0]            LAST_COL  = 6'(COLS-1);
  localparam logic [4:0]            LAST_ROW  = 5'(ROWS-1);

  osd_wr_state_t         state, state_nxt;
  logic [3:0]            lo_nib, lo_nib_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr, wr_addr_nxt;
  logic [7:0]            wr_data_nxt;
  logic                  wr_en_nxt;
  logic [5:0]            col_nxt, adv_col;
  logic [4:0]            row_nxt, adv_row, row_inc;

  // Cursor arithmetic: linear address and the position after one advance.
  always_comb begin
    cur_addr = ADDR_WIDTH'(cursor_row) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(cursor_col);
    row_inc  = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
    if (cursor_col == LAST_COL) begin
      adv_col = 6'd0;
      adv_row = row_inc;
    end else begin
      adv_col = cursor_col + 6'd1;
      adv_row = cursor_row;
    end
  end

  always_comb begin
    in_ready = ((state == ST_IDLE) || (state == ST_ESC_COL) || (state == ST_ESC_ROW))
               && !clear_req;
    busy     = (state == ST_CLEAR) || (state == ST_HEX_LO);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (clear_req)                          state_nxt = ST_CLEAR;
        else if (in_valid && in_hex)            state_nxt = ST_HEX_LO;
        else if (in_valid && in_data == CC_FF)  state_nxt = ST_CLEAR;
        else if (in_valid && in_data == CC_ESC) state_nxt = ST_ESC_COL;
      end
      ST_ESC_COL: begin
        if (clear_req)     state_nxt = ST_CLEAR;
        else if (in_valid) state_nxt = ST_ESC_ROW;
      end
      ST_ESC_ROW: begin
        if (clear_req)     state_nxt = ST_CLEAR;
        else if (in_valid) state_nxt = ST_IDLE;
      end
      // A clear arriving while the low digit is pending is honoured right
      // after that digit is written.
      ST_HEX_LO: state_nxt = clear_req ? ST_CLEAR : ST_IDLE;
      ST_CLEAR:  if (clr_cnt == LAST_CELL) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the write port, cursor and counters
  always_comb begin
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    col_nxt     = cursor_col;
    row_nxt     = cursor_row;
    lo_nib_nxt  = lo_nib;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_IDLE: begin
        if (in_valid && !clear_req) begin
          if (in_hex) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = cur_addr;
            wr_data_nxt = hex_ascii(in_data[7:4]);
            col_nxt     = adv_col;
            row_nxt     = adv_row;
            lo_nib_nxt  = in_data[3:0];
          end else if (in_data >= 8'h20) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = cur_addr;
            wr_data_nxt = in_data;
            col_nxt     = adv_col;
            row_nxt     = adv_row;
          end else if (in_data == CC_CR) begin
            col_nxt = 6'd0;
          end else if (in_data == CC_LF) begin
            col_nxt = 6'd0;
            row_nxt = row_inc;
          end
        end
      end
      ST_ESC_COL: begin
        if (in_valid && !clear_req)
          col_nxt = (in_data > 8'(COLS-1)) ? LAST_COL : in_data[5:0];
      end
      ST_ESC_ROW: begin
        if (in_valid && !clear_req)
          row_nxt = (in_data > 8'(ROWS-1)) ? LAST_ROW : in_data[4:0];
      end
      ST_HEX_LO: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = cur_addr;
        wr_data_nxt = hex_ascii(lo_nib);
        col_nxt     = adv_col;
        row_nxt     = adv_row;
      end
      ST_CLEAR: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = clr_cnt;
        wr_data_nxt = BLANK_CHAR;
        // Counter idles at zero outside CLEAR, so entry needs no preload.
        if (clr_cnt == LAST_CELL) begin
          clr_cnt_nxt = '0;
          col_nxt     = 6'd0;
          row_nxt     = 5'd0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered write port and cursor
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'h00;
      cursor_col <= 6'd0;
      cursor_row <= 5'd0;
      lo_nib     <= 4'h0;
      clr_cnt    <= '0;
    end else begin
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      cursor_col <= col_nxt;
      cursor_row <= row_nxt;
      lo_nib     <= lo_nib_nxt;
      clr_cnt    <= clr_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_osd_console_writer.sv
// Self-checking bench for osd_console_writer: directed scenarios plus a
// randomized byte stream, checked every cycle against a transaction-level
// model of the console (cursor, escape/hex/clear modes, expected write list).
module tb_osd_console_writer;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int NCELL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_hex = 1'b0;
  logic        clear_req = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, wr_en, busy;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;

  always #5 clk = ~clk;

  osd_console_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_hex     (in_hex),
    .clear_req  (clear_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .busy       (busy),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t m_q[$];
  int  m_cyc = 0, m_gen = 0, m_col = 0, m_row = 0, m_esc = 0, m_clr = 0, m_lo = 0, m_d = 0;
  bit  m_hexlo = 1'b0;

  function automatic int hexc(int n);
    return (n < 10) ? ('h30 + n) : ('h41 + n - 10);
  endfunction

  // Write at the cursor, visible after the current edge, then advance.
  function automatic void m_put(int d);
    wr_t w;
    w.cyc = m_cyc; w.addr = m_row * COLS + m_col; w.data = d;
    m_q.push_back(w);
    m_col++;
    if (m_col == COLS) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
    end
  endfunction

  function automatic void m_clear();
    wr_t w;
    for (int i = 0; i < NCELL; i++) begin
      w.cyc = m_cyc + 1 + i; w.addr = i; w.data = 'h20;
      m_q.push_back(w);
    end
    m_clr = NCELL;
    m_esc = 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_gen++;
      m_cyc = 0; m_col = 0; m_row = 0; m_esc = 0; m_clr = 0; m_hexlo = 1'b0;
    end else begin
      m_cyc++;
      m_d = int'(in_data);
      if (m_clr > 0) begin
        m_clr--;
        if (m_clr == 0) begin m_col = 0; m_row = 0; end
      end else if (m_hexlo) begin
        m_put(hexc(m_lo));
        m_hexlo = 1'b0;
        if (clear_req) m_clear();
      end else if (clear_req) begin
        m_clear();
      end else if (in_valid) begin
        if (m_esc == 1) begin
          m_col = (m_d > COLS - 1) ? COLS - 1 : m_d; m_esc = 2;
        end else if (m_esc == 2) begin
          m_row = (m_d > ROWS - 1) ? ROWS - 1 : m_d; m_esc = 0;
        end else if (in_hex) begin
          m_put(hexc(m_d / 16)); m_lo = m_d % 16; m_hexlo = 1'b1;
        end else if (m_d >= 'h20) m_put(m_d);
        else if (m_d == 'h0D) m_col = 0;
        else if (m_d == 'h0A) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
        else if (m_d == 'h0C) m_clear();
        else if (m_d == 'h1B) m_esc = 1;
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0, passed = 0, rd = 0, seen_gen = 0;
  int wr_cnt = 0, blank_cnt = 0, last_addr = -1, last_data = -1, c0 = 0;
  bit found;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic compare();
    bit due;
    if (!reset_n) return;
    if (seen_gen != m_gen) begin seen_gen = m_gen; rd = 0; end
    check("in_ready", int'(in_ready), int'(m_clr == 0 && !m_hexlo && !clear_req));
    check("busy", int'(busy), int'(m_clr > 0 || m_hexlo));
    check("cursor_col", int'(cursor_col), m_col);
    check("cursor_row", int'(cursor_row), m_row);
    due = (rd < m_q.size()) && (m_q[rd].cyc == m_cyc);
    check("wr_en", int'(wr_en), int'(due));
    if (due) begin
      if (wr_en) begin
        check("wr_addr", int'(wr_addr), m_q[rd].addr);
        check("wr_data", int'(wr_data), m_q[rd].data);
      end
      rd++;
    end
    if (wr_en) begin
      wr_cnt++;
      if (wr_data == 8'h20) blank_cnt++;
      last_addr = int'(wr_addr);
      last_data = int'(wr_data);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic h);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_hex = h;
    for (int n = 0; n < 2000 && !ok; n++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0; in_hex = 1'b0;
    if (!ok) fail_now("send_handshake");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 1500 && !ok; n++) begin
      if (!busy && m_clr == 0 && !m_hexlo) ok = 1'b1;
      else tick();
    end
    if (!ok) fail_now("wait_idle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_col", int'(cursor_col), 0);
    check("rst_row", int'(cursor_row), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);
    reset_n = 1'b1;
    tick();

    // "AB"
    send(8'h41, 1'b0); send(8'h42, 1'b0); tick(); tick();
    check("ab_last_addr", last_addr, 1);
    check("ab_last_data", last_data, 'h42);
    check("ab_col", int'(cursor_col), 2);
    check("ab_row", int'(cursor_row), 0);

    // bottom-right wrap
    send(8'h1B, 1'b0); send(8'd39, 1'b0); send(8'd29, 1'b0);
    send(8'h5A, 1'b0); tick();
    check("wrap_z_addr", last_addr, 1199);
    check("wrap_z_data", last_data, 'h5A);
    send(8'h59, 1'b0); tick();
    check("wrap_y_addr", last_addr, 0);
    check("wrap_y_data", last_data, 'h59);
    check("wrap_col", int'(cursor_col), 1);
    check("wrap_row", int'(cursor_row), 0);

    // clamped escape, no writes
    c0 = wr_cnt;
    send(8'h1B, 1'b0); send(8'd50, 1'b0); send(8'd40, 1'b0); tick();
    check("clamp_no_write", wr_cnt, c0);
    check("clamp_col", int'(cursor_col), 39);
    check("clamp_row", int'(cursor_row), 29);

    // hex byte 0x3F at (5,2)
    send(8'h1B, 1'b0); send(8'd5, 1'b0); send(8'd2, 1'b0);
    send(8'h3F, 1'b1);
    check("hex_lo_ready", int'(in_ready), 0);
    check("hex_lo_busy", int'(busy), 1);
    tick();
    check("hex_hi_addr", last_addr, 85);
    check("hex_hi_data", last_data, 'h33);
    check("hex_ready_back", int'(in_ready), 1);
    tick();
    check("hex_lo_addr", last_addr, 86);
    check("hex_lo_data", last_data, 'h46);
    check("hex_col", int'(cursor_col), 7);
    check("hex_row", int'(cursor_row), 2);

    // form feed clear, input held valid, clear_req ignored mid-clear
    blank_cnt = 0;
    send(8'h0C, 1'b0);
    check("ff_busy", int'(busy), 1);
    in_valid = 1'b1; in_data = 8'h0D;
    for (int i = 0; i < 600; i++) tick();
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    wait_idle();
    in_valid = 1'b0;
    tick();
    check("ff_blank_count", blank_cnt, NCELL);
    check("ff_col", int'(cursor_col), 0);
    check("ff_row", int'(cursor_row), 0);

    // clear_req while the low hex digit is pending
    send(8'h1B, 1'b0); send(8'd3, 1'b0); send(8'd3, 1'b0);
    blank_cnt = 0;
    send(8'hA7, 1'b1);
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    check("hexclr_hi_addr", last_addr, 123);
    check("hexclr_hi_data", last_data, 'h41);
    tick();
    check("hexclr_lo_addr", last_addr, 124);
    check("hexclr_lo_data", last_data, 'h37);
    check("hexclr_busy", int'(busy), 1);
    wait_idle(); tick();
    check("hexclr_blank_count", blank_cnt, NCELL);

    // clear_req with a simultaneous byte, then reset at address 600
    send(8'h51, 1'b0);
    clear_req = 1'b1; in_valid = 1'b1; in_data = 8'h51;
    tick();
    clear_req = 1'b0; in_valid = 1'b0;
    check("clrreq_busy", int'(busy), 1);
    found = 1'b0;
    for (int n = 0; n < 1400 && !found; n++) begin
      @(negedge clk);
      compare();
      if (wr_en && wr_addr == 11'd600) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!found) fail_now("reach_addr_600");
    reset_n = 1'b0;
    #1;
    check("rstmid_wr_en", int'(wr_en), 0);
    check("rstmid_in_ready", int'(in_ready), 1);
    check("rstmid_busy", int'(busy), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    check("rstmid_col", int'(cursor_col), 0);
    check("rstmid_row", int'(cursor_row), 0);

    // randomized stream
    for (int i = 0; i < 6000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_hex    = ($urandom % 5) == 0;
      clear_req = ($urandom % 800) == 0;
      case ($urandom % 16)
        0: in_data = 8'h0D;
        1: in_data = 8'h0A;
        2: in_data = 8'h1B;
        3: in_data = 8'($urandom % 32);
        4: in_data = (($urandom % 50) == 0) ? 8'h0C : 8'h05;
        default: in_data = 8'($urandom);
      endcase
      if (in_data == 8'h0C && m_esc == 0) in_hex = 1'b0;
      tick();
    end
    in_valid = 1'b0; in_hex = 1'b0; clear_req = 1'b0;
    wait_idle();
    tick();
    check("all_writes_seen", rd, m_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
